// File: rtl/shift_mac_seq_if.sv
// Handshake bundle for shift_mac_seq: weight load, activation stream, result
// channel plus reload/status. The feeder side is master, the PE sequencer is slave.
interface shift_mac_seq_if #(
    parameter int unsigned ACC_WIDTH = 16
);
    localparam int unsigned DATA_WEIGHT_WIDTH = 4;
    localparam int unsigned DATA_ACT_WIDTH    = 8;

    logic                                w_valid;
    logic                                w_ready;
    logic        [DATA_WEIGHT_WIDTH-1:0] w_data;
    logic                                act_valid;
    logic                                act_ready;
    logic signed [DATA_ACT_WIDTH-1:0]    act_data;
    logic                                reload;
    logic                                res_valid;
    logic                                res_ready;
    logic signed [ACC_WIDTH-1:0]         res_data;
    logic                                weights_loaded;

    modport master (
        output w_valid, w_data, act_valid, act_data, reload, res_ready,
        input  w_ready, act_ready, res_valid, res_data, weights_loaded
    );

    modport slave (
        input  w_valid, w_data, act_valid, act_data, reload, res_ready,
        output w_ready, act_ready, res_valid, res_data, weights_loaded
    );
endinterface

// File: rtl/shift_mac_seq.sv
// Weight-stationary shift-MAC sequencer: loads a kernel of log-quantized weights,
// streams activations through one shift unit and returns one dot product per window.
// Optional SHIFT_ACC_SAT_EN: saturating accumulator instead of two's-complement wrap.
module shift_mac_seq #(
    parameter int unsigned KERNEL_LEN = 9,
    parameter int unsigned ACC_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_mac_seq_if.slave     bus
);
    localparam int unsigned DATA_WEIGHT_WIDTH = 4;
    localparam int unsigned DATA_ACT_WIDTH    = 8;
    localparam int unsigned DATA_INTER_WIDTH  = 16;
    localparam int unsigned SHL               = DATA_INTER_WIDTH - DATA_ACT_WIDTH - 1;
    localparam int unsigned IDX_W             = $clog2(KERNEL_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(KERNEL_LEN - 1);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN, S_OUT} state_t;

    state_t                              state;
    state_t                              state_nx;
    logic        [IDX_W-1:0]             idx;
    logic        [DATA_WEIGHT_WIDTH-1:0] wbuf [KERNEL_LEN];
    logic signed [DATA_INTER_WIDTH-1:0]  p_reg;
    logic                                p_vld;
    logic signed [ACC_WIDTH-1:0]         acc;

    logic                                idx_last;
    logic                                w_fire;
    logic                                act_fire;
    logic                                res_fire;
    logic                                reload_go;
    logic        [DATA_WEIGHT_WIDTH-1:0] w_sel;
    logic signed [DATA_ACT_WIDTH:0]      x_ext;
    logic signed [DATA_ACT_WIDTH:0]      x_inv;
    logic signed [DATA_INTER_WIDTH-1:0]  prod_c;
    logic signed [ACC_WIDTH-1:0]         acc_sum;

    assign idx_last = (idx == IDX_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_nx;
    end

    // Next state and handshake qualification; reload at a window boundary
    // takes priority and blocks the activation accept in that cycle.
    always_comb begin
        state_nx  = state;
        w_fire    = 1'b0;
        act_fire  = 1'b0;
        res_fire  = 1'b0;
        reload_go = 1'b0;
        case (state)
            S_LOAD: begin
                w_fire = bus.w_valid & bus.w_ready;
                if (w_fire && idx_last) state_nx = S_RUN;
            end
            S_RUN: begin
                reload_go = bus.reload & (idx == '0) & ~p_vld;
                act_fire  = bus.act_valid & bus.act_ready & ~reload_go;
                if (reload_go)                 state_nx = S_LOAD;
                else if (act_fire && idx_last) state_nx = S_DRAIN;
            end
            S_DRAIN: state_nx = S_OUT;
            S_OUT: begin
                res_fire = bus.res_valid & bus.res_ready;
                if (res_fire) state_nx = S_RUN;
            end
            default: state_nx = S_LOAD;
        endcase
    end

    // Shift unit: conditional negate at 9 bits, scale by 2^7, arithmetic right shift
    always_comb begin
        w_sel  = wbuf[idx];
        x_ext  = {bus.act_data[DATA_ACT_WIDTH-1], bus.act_data};
        x_inv  = w_sel[DATA_WEIGHT_WIDTH-1] ? -x_ext : x_ext;
        prod_c = $signed({x_inv, {SHL{1'b0}}}) >>> w_sel[DATA_WEIGHT_WIDTH-2:0];
    end

`ifdef SHIFT_ACC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic signed [ACC_WIDTH:0] sum_w;

    // One guard bit detects overflow; clamp toward the sign of the true sum
    always_comb begin
        sum_w = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(p_reg);
        if (sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1])
            acc_sum = sum_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        else
            acc_sum = sum_w[ACC_WIDTH-1:0];
    end
`else
    always_comb begin
        acc_sum = acc + ACC_WIDTH'(p_reg);
    end
`endif

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(KERNEL_LEN); i++) wbuf[i] <= '0;
            idx                <= '0;
            p_reg              <= '0;
            p_vld              <= 1'b0;
            acc                <= '0;
            bus.w_ready        <= 1'b1;
            bus.act_ready      <= 1'b0;
            bus.res_valid      <= 1'b0;
            bus.res_data       <= '0;
            bus.weights_loaded <= 1'b0;
        end else begin
            if (w_fire) wbuf[idx] <= bus.w_data;
            if (w_fire || act_fire) idx <= idx_last ? '0 : idx + IDX_W'(1);

            p_vld <= act_fire;
            if (act_fire) p_reg <= prod_c;

            if (res_fire)   acc <= '0;
            else if (p_vld) acc <= acc_sum;

            // DRAIN always holds the last product, so acc_sum is the window total
            if (state == S_DRAIN) bus.res_data <= acc_sum;

            bus.w_ready   <= (state_nx == S_LOAD);
            bus.act_ready <= (state_nx == S_RUN);
            bus.res_valid <= (state_nx == S_OUT);

            if (w_fire && idx_last) bus.weights_loaded <= 1'b1;
            else if (reload_go)     bus.weights_loaded <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shift_mac_seq.sv
// Scoreboarded bench for shift_mac_seq: stimulus pushes model results into a
// queue, a negedge monitor pops and compares on every result handshake.
module tb_shift_mac_seq;
    localparam int KL     = 9;
    localparam int BUDGET = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_mac_seq_if #(.ACC_WIDTH(16)) bus ();

    shift_mac_seq #(.KERNEL_LEN(KL), .ACC_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         errors = 0;
    int         checks = 0;
    int         exp_q[$];
    logic [3:0] wts[KL];
    int         acts[KL];

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endfunction

    // Reference: dot product of sign-applied activations scaled by 2^7 / 2^shift
    function automatic int model();
        longint s = 0;
        for (int i = 0; i < KL; i++) begin
            int xi = wts[i][3] ? -acts[i] : acts[i];
            int p  = (xi * 128) >>> int'(wts[i][2:0]);
            s += p;
`ifdef SHIFT_ACC_SAT_EN
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
`endif
        end
        begin
            logic signed [15:0] r = 16'(s);
            return int'(r);
        end
    endfunction

    // Result monitor
    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) tmo("unexpected_result");
            else                   chk("res_data", int'(bus.res_data), exp_q.pop_front());
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_w_ready"},        int'(bus.w_ready), 1);
        chk({tag, "_act_ready"},      int'(bus.act_ready), 0);
        chk({tag, "_res_valid"},      int'(bus.res_valid), 0);
        chk({tag, "_res_data"},       int'(bus.res_data), 0);
        chk({tag, "_weights_loaded"}, int'(bus.weights_loaded), 0);
    endtask

    task automatic send_w(input logic [3:0] d);
        int   n = 0;
        logic fire;
        bus.w_valid = 1'b1;
        bus.w_data  = d;
        do begin
            @(negedge clk);
            fire = bus.w_ready;
            @(posedge clk); #1;
            n++;
        end while (!fire && n < BUDGET);
        if (!fire) tmo("w_accept");
        bus.w_valid = 1'b0;
    endtask

    task automatic send_a(input int d, input bit gaps);
        int   n = 0;
        int   g = gaps ? int'($urandom_range(0, 2)) : 0;
        logic fire;
        bus.act_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
        bus.act_valid = 1'b1;
        bus.act_data  = 8'(d);
        do begin
            @(negedge clk);
            fire = bus.act_ready;
            @(posedge clk); #1;
            n++;
        end while (!fire && n < BUDGET);
        if (!fire) tmo("act_accept");
        bus.act_valid = 1'b0;
    endtask

    task automatic load_kernel();
        for (int i = 0; i < KL; i++) send_w(wts[i]);
    endtask

    task automatic run_window(input bit gaps);
        exp_q.push_back(model());
        for (int i = 0; i < KL; i++) send_a(acts[i], gaps);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < BUDGET) begin @(posedge clk); #1; n++; end
        if (exp_q.size() != 0) begin
            tmo("result_wait");
            exp_q.delete();
        end
    endtask

    task automatic do_reload();
        bus.reload = 1'b1;
        @(posedge clk); #1;
        bus.reload = 1'b0;
        chk("reload_weights_loaded", int'(bus.weights_loaded), 0);
        chk("reload_w_ready", int'(bus.w_ready), 1);
    endtask

    task automatic rand_kernel();
        for (int i = 0; i < KL; i++) wts[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic rand_acts();
        for (int i = 0; i < KL; i++) acts[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.w_valid = 1'b0; bus.w_data = '0;
        bus.act_valid = 1'b0; bus.act_data = '0;
        bus.reload = 1'b0; bus.res_ready = 1'b1;

        // Reset for two cycles, then load the 0011 kernel
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        for (int i = 0; i < KL; i++) wts[i] = 4'b0011;
        load_kernel();
        chk("loaded_flag", int'(bus.weights_loaded), 1);
        chk("loaded_w_ready", int'(bus.w_ready), 0);
        chk("loaded_act_ready", int'(bus.act_ready), 1);

        // Basic window with latency check
        for (int i = 0; i < KL; i++) acts[i] = 8;
        run_window(1'b0);
        chk("drain_res_valid", int'(bus.res_valid), 0);
        chk("drain_act_ready", int'(bus.act_ready), 0);
        @(posedge clk); #1;
        chk("lat2_res_valid", int'(bus.res_valid), 1);
        wait_empty();

        // Sign and shift
        do_reload();
        for (int i = 0; i < KL; i++) wts[i] = (i % 2 == 0) ? 4'b1000 : 4'b0111;
        load_kernel();
        run_window(1'b0);
        wait_empty();

        // Overflow: -128 negated to +128, nine products of 16384
        do_reload();
        for (int i = 0; i < KL; i++) begin wts[i] = 4'b1000; acts[i] = -128; end
        load_kernel();
        run_window(1'b0);
        wait_empty();

        // Backpressure with gaps, then a following gapped window
        do_reload();
        rand_kernel();
        load_kernel();
        bus.res_ready = 1'b0;
        rand_acts();
        run_window(1'b1);
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            chk("stall_res_valid", int'(bus.res_valid), 1);
            chk("stall_act_ready", int'(bus.act_ready), 0);
            if (exp_q.size() != 0) chk("stall_res_data", int'(bus.res_data), exp_q[0]);
            else                   tmo("stall_expect");
            @(posedge clk); #1;
        end
        bus.res_ready = 1'b1;
        wait_empty();
        rand_acts();
        run_window(1'b1);
        wait_empty();

        // Reload mid-window is ignored
        rand_acts();
        exp_q.push_back(model());
        for (int i = 0; i < 4; i++) send_a(acts[i], 1'b0);
        bus.reload = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus.reload = 1'b0;
        chk("midreload_loaded", int'(bus.weights_loaded), 1);
        chk("midreload_w_ready", int'(bus.w_ready), 0);
        chk("midreload_act_ready", int'(bus.act_ready), 1);
        for (int i = 4; i < KL; i++) send_a(acts[i], 1'b0);
        wait_empty();

        // Reload at a window boundary; new weights take effect
        do_reload();
        rand_kernel();
        load_kernel();
        rand_acts();
        run_window(1'b1);
        wait_empty();

        // Reset at idx 4 discards the window
        rand_acts();
        for (int i = 0; i < 4; i++) send_a(acts[i], 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        rst_n = 1'b1;
        rand_kernel();
        load_kernel();
        rand_acts();
        run_window(1'b1);
        wait_empty();

        // Random kernels and windows
        for (int k = 0; k < 4; k++) begin
            do_reload();
            rand_kernel();
            load_kernel();
            for (int j = 0; j < 2; j++) begin
                rand_acts();
                run_window(1'b1);
                wait_empty();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
